host_io_switch: RTL

//  Parametrised, sequential successor to the FTDI host pin mux. Muxes DATA_W shared host pads between
//  the sync-FIFO, SPI-slave and UART cores. Host mode changes at run time through a drain/turnaround FSM,
//  so two drivers never overlap on a pad. Provides synchroniser/filtered pad inputs to the SPI/UART cores.

---
 rtl/host_io_switch.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/host_io_switch.sv
// Shared host pad switch: sync-FIFO / SPI-slave / UART with a drain + turnaround FSM.
// Optional ss_n/rxd glitch filter is built when HOST_IO_GLITCH_FILT_EN is defined.
module host_io_switch #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int TURN_CYC    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        host_mode_req,
  input  logic              flow_control,
  input  logic              unused_io,
  output logic [1:0]        mode_active,
  output logic              mode_valid,
  input  logic [DATA_W-1:0] pad_in,
  output logic [DATA_W-1:0] pad_out,
  output logic [DATA_W-1:0] pad_oe,
  input  logic              rxf_n_in,
  input  logic              txe_n_in,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              oe_n,
  output logic              rd_n_pad,
  output logic              wr_n_pad,
  output logic              oe_n_pad,
  output logic              ctrl_pad_oe,
  input  logic [DATA_W-1:0] sfifo_data_out,
  input  logic              sfifo_data_oe,
  output logic [DATA_W-1:0] sfifo_data_in,
  output logic              rxf_n,
  output logic              txe_n,
  output logic              sck,
  output logic              mosi,
  output logic              ss_n,
  input  logic              miso,
  input  logic              txd,
  input  logic              rts,
  output logic              rxd,
  output logic              cts
);
  localparam logic [1:0] MODE_SFIFO = 2'b01;
  localparam logic [1:0] MODE_SPI   = 2'b10;
  localparam logic [1:0] MODE_UART  = 2'b11;
  localparam logic [7:0] TURN_LAST  = 8'(TURN_CYC - 1);
  // sync vector bits: {ss_n, cts_n, mosi, rxd, sck}, reset to their idle levels
  localparam logic [4:0] SYNC_IDLE  = 5'b10010;

  typedef enum logic [1:0] {ST_ACTIVE = 2'd0, ST_DRAIN = 2'd1, ST_TURN = 2'd2} state_t;

  state_t     state_q, state_d;
  logic [7:0] turn_cnt_q, turn_cnt_d;
  logic [1:0] mode_q, mode_d;
  logic [1:0] req_meta_q, req_meta_d, req_sync_q, req_sync_d, req_q, req_d, req_last_q, req_last_d;
  logic       qual_q, qual_d;
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] sync_d [SYNC_STAGES];
  logic [4:0] samp_s;
  logic       ss_f_s, rxd_f_s, change_s, idle_s, drive_s, spi_on_s, uart_on_s;

  assign samp_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = {pad_in[3], pad_in[2], pad_in[1], pad_in[0], pad_in[0]};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
    end
  end

`ifdef HOST_IO_GLITCH_FILT_EN
  localparam logic [4:0] FILT_MAX = 5'(FILT_LEN);
  logic [1:0]      filt_q, filt_d;   // {ss_n, rxd}
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic [1:0]      fin_s;

  assign fin_s = {samp_s[4], samp_s[1]};

  // Output flips only after FILT_LEN consecutive differing samples; an agreeing sample clears the run.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (fin_s[i] == filt_q[i]) begin
        fcnt_d[i] = 4'd0;
      end else if (({1'b0, fcnt_q[i]} + 5'd1) >= FILT_MAX) begin
        filt_d[i] = fin_s[i];
        fcnt_d[i] = 4'd0;
      end else if (fcnt_q[i] != 4'hF) begin
        fcnt_d[i] = fcnt_q[i] + 4'd1;
      end else begin
        fcnt_d[i] = fcnt_q[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= 2'b11;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign ss_f_s  = filt_q[1];
  assign rxd_f_s = filt_q[0];
`else
  assign ss_f_s  = samp_s[4];
  assign rxd_f_s = samp_s[1];
`endif

  assign change_s = (req_q != mode_q);

  always_comb begin
    case (mode_q)
      MODE_SFIFO: idle_s = oe_n & wr_n & ~sfifo_data_oe;
      MODE_SPI:   idle_s = ss_f_s;
      default:    idle_s = 1'b1;
    endcase
  end

  always_comb begin
    req_meta_d = host_mode_req;
    req_sync_d = req_meta_q;
    req_d      = req_sync_q;
    req_last_d = req_q;
    qual_d     = change_s;
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    mode_d     = mode_q;
    case (state_q)
      ST_ACTIVE: begin
        if (change_s && qual_q) state_d = ST_DRAIN;
        else                    state_d = ST_ACTIVE;
      end
      ST_DRAIN: begin
        if (!change_s) begin
          state_d = ST_ACTIVE;
        end else if (idle_s) begin
          state_d    = ST_TURN;
          turn_cnt_d = 8'd0;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_TURN: begin
        // a moving request restarts the release window so the new owner gets a full turnaround
        if (req_q != req_last_q) begin
          turn_cnt_d = 8'd0;
        end else if (turn_cnt_q == TURN_LAST) begin
          mode_d     = req_q;
          state_d    = ST_ACTIVE;
          turn_cnt_d = 8'd0;
        end else begin
          turn_cnt_d = turn_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = ST_TURN;
        turn_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_TURN;
      turn_cnt_q <= 8'd0;
      mode_q     <= 2'b00;
      req_meta_q <= 2'b00;
      req_sync_q <= 2'b00;
      req_q      <= 2'b00;
      req_last_q <= 2'b00;
      qual_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      turn_cnt_q <= turn_cnt_d;
      mode_q     <= mode_d;
      req_meta_q <= req_meta_d;
      req_sync_q <= req_sync_d;
      req_q      <= req_d;
      req_last_q <= req_last_d;
      qual_q     <= qual_d;
    end
  end

  assign mode_active   = mode_q;
  assign mode_valid    = (state_q == ST_ACTIVE);
  assign drive_s       = (state_q != ST_TURN);
  assign spi_on_s      = mode_valid && (mode_q == MODE_SPI);
  assign uart_on_s     = mode_valid && (mode_q == MODE_UART);
  assign sfifo_data_in = pad_in;
  assign ctrl_pad_oe   = drive_s;

  assign sck  = spi_on_s  ? samp_s[0] : 1'b0;
  assign mosi = spi_on_s  ? samp_s[2] : 1'b0;
  assign ss_n = spi_on_s  ? ss_f_s    : 1'b1;
  assign rxd  = uart_on_s ? rxd_f_s   : 1'b1;
  assign cts  = uart_on_s ? ~samp_s[3] : 1'b1;

  // Pad ownership: the old mode keeps driving through DRAIN; everything floats in TURN.
  always_comb begin
    pad_out  = '0;
    pad_oe   = '0;
    rd_n_pad = 1'b1;
    wr_n_pad = 1'b1;
    oe_n_pad = 1'b1;
    rxf_n    = 1'b1;
    txe_n    = 1'b1;
    if (drive_s) begin
      case (mode_q)
        MODE_SFIFO: begin
          pad_out  = sfifo_data_oe ? sfifo_data_out : '0;
          pad_oe   = {DATA_W{sfifo_data_oe}};
          rd_n_pad = rd_n;
          wr_n_pad = wr_n;
          oe_n_pad = oe_n;
          rxf_n    = rxf_n_in;
          txe_n    = txe_n_in;
        end
        MODE_SPI: begin
          pad_oe[DATA_W-1:4] = {(DATA_W-4){unused_io}};
          pad_oe[2]          = ~ss_f_s;
          pad_out[2]         = ~ss_f_s & miso;
        end
        MODE_UART: begin
          pad_oe[DATA_W-1:4] = {(DATA_W-4){unused_io}};
          pad_oe[1]          = 1'b1;
          pad_out[1]         = txd;
          pad_oe[3]          = flow_control | unused_io;
          pad_out[3]         = flow_control & rts;
          pad_oe[2]          = ~flow_control & unused_io;
        end
        default: begin
          pad_oe = {DATA_W{unused_io}};
        end
      endcase
    end else begin
      pad_oe = '0;
    end
  end
endmodule
